// File: rtl/hamming_odd_pkg.sv
// Shared definitions for the odd-parity Hamming(7,4) codeword format.
package hamming_odd_pkg;

    // Codeword geometry: bit i holds Hamming position i+1.
    localparam int unsigned CODE_W = 7;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned SYN_W  = 3;

    localparam int unsigned P1_IDX = 0;
    localparam int unsigned P2_IDX = 1;
    localparam int unsigned D_IDX  = 2;
    localparam int unsigned P3_IDX = 3;
    localparam int unsigned C_IDX  = 4;
    localparam int unsigned B_IDX  = 5;
    localparam int unsigned A_IDX  = 6;

    // One decoded result as held in the output register.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SYN_W-1:0]  syndrome;
        logic              corrected;
    } dec_word_t;

    // A check group is healthy when its four bits XOR to 1; returns 1 on violation.
    function automatic logic odd_check(input logic b0, input logic b1,
                                       input logic b2, input logic b3);
        return ~(b0 ^ b1 ^ b2 ^ b3);
    endfunction

    // Pull the data bits {a,b,c,d} out of a codeword.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        return {code[A_IDX], code[B_IDX], code[C_IDX], code[D_IDX]};
    endfunction

endpackage

// File: rtl/hamming_syndrome_odd.sv
// Combinational syndrome computation and single-bit correction.
module hamming_syndrome_odd
    import hamming_odd_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYN_W-1:0]  syndrome,
    output logic [CODE_W-1:0] fixed,
    output logic [DATA_W-1:0] data
);

    logic [CODE_W-1:0] flip_mask;

    // Syndrome names the failing position; flip that bit and extract data.
    always_comb begin
        syndrome = {odd_check(code[P3_IDX], code[C_IDX], code[B_IDX], code[A_IDX]),
                    odd_check(code[P2_IDX], code[D_IDX], code[B_IDX], code[A_IDX]),
                    odd_check(code[P1_IDX], code[D_IDX], code[C_IDX], code[A_IDX])};
        flip_mask = '0;
        for (int unsigned i = 0; i < CODE_W; i++) begin
            flip_mask[i] = (syndrome == SYN_W'(i + 1));
        end
        fixed = code ^ flip_mask;
        data  = extract_data(fixed);
    end

endmodule

// File: rtl/hamming_decoder_odd.sv
// Odd-parity Hamming(7,4) decoder with registered output stage and link statistics.
module hamming_decoder_odd
    import hamming_odd_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [SYN_W-1:0]  syndrome,
    output logic              corrected,
    input  logic              clear_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  clean_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYN_W-1:0]  syn_c;
    logic [CODE_W-1:0] fixed_c;
    logic [DATA_W-1:0] data_c;
    logic              xfer_in_c;
    logic              xfer_out_c;

    logic              out_valid_q, out_valid_d;
    dec_word_t         word_q, word_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  clean_cnt_q, clean_cnt_d;

    hamming_syndrome_odd u_syndrome (
        .code     (code_in),
        .syndrome (syn_c),
        .fixed    (fixed_c),
        .data     (data_c)
    );

    // Handshake: the single output slot can take a word when empty or draining.
    always_comb begin
        in_ready   = !out_valid_q | out_ready;
        xfer_in_c  = in_valid & in_ready;
        xfer_out_c = out_valid_q & out_ready;
    end

    // Next-state for the output slot and the saturating counters.
    always_comb begin
        out_valid_d = out_valid_q;
        word_d      = word_q;
        corr_cnt_d  = corr_cnt_q;
        clean_cnt_d = clean_cnt_q;

        if (xfer_in_c) begin
            out_valid_d      = 1'b1;
            word_d.data      = data_c;
            word_d.syndrome  = syn_c;
            word_d.corrected = |(fixed_c ^ code_in);
        end else if (xfer_out_c) begin
            out_valid_d = 1'b0;
        end

        if (clear_cnt) begin
            corr_cnt_d  = '0;
            clean_cnt_d = '0;
        end else if (xfer_in_c) begin
            if (syn_c != '0) begin
                if (corr_cnt_q != CNT_MAX) corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end else begin
                if (clean_cnt_q != CNT_MAX) clean_cnt_d = clean_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            word_q      <= '0;
            corr_cnt_q  <= '0;
            clean_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            word_q      <= word_d;
            corr_cnt_q  <= corr_cnt_d;
            clean_cnt_q <= clean_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = word_q.data;
    assign syndrome  = word_q.syndrome;
    assign corrected = word_q.corrected;
    assign corr_cnt  = corr_cnt_q;
    assign clean_cnt = clean_cnt_q;

endmodule

// File: tb/tb_hamming_decoder_odd.sv
// Directed bench for hamming_decoder_odd: clean/corrupted words, exhaustive flips,
// backpressure, counter saturation/clear and asynchronous reset.
module tb_hamming_decoder_odd;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, corrected, clear_cnt;
    logic [6:0]  code_in;
    logic [3:0]  data_out;
    logic [2:0]  syndrome;
    logic [15:0] corr_cnt, clean_cnt;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_corrected, s_clear_cnt;
    logic [6:0]  s_code_in;
    logic [3:0]  s_data_out;
    logic [2:0]  s_syndrome;
    logic [1:0]  s_corr_cnt, s_clean_cnt;

    int n_cmp = 0;
    int n_err = 0;

    hamming_decoder_odd #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .syndrome(syndrome), .corrected(corrected),
        .clear_cnt(clear_cnt), .corr_cnt(corr_cnt), .clean_cnt(clean_cnt)
    );

    hamming_decoder_odd #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .code_in(s_code_in),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .data_out(s_data_out), .syndrome(s_syndrome), .corrected(s_corrected),
        .clear_cnt(s_clear_cnt), .corr_cnt(s_corr_cnt), .clean_cnt(s_clean_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent odd-parity encoder: {a,b,c,d} -> {a,b,c,p3,d,p2,p1}.
    function automatic logic [6:0] enc(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return {a, b, c, ~(c ^ b ^ a), d, ~(d ^ b ^ a), ~(d ^ c ^ a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] w;
        logic [6:0] mask;
        int         exp_sat;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; clear_cnt = 1'b0; code_in = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_clear_cnt = 1'b0; s_code_in = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_syndrome", 32'(syndrome), 32'd0);
        chk("rst_corrected", 32'(corrected), 32'd0);
        chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
        chk("rst_clean_cnt", 32'(clean_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Clean words.
        in_valid = 1'b1; code_in = 7'h0B;
        tick();
        chk("clean0_valid", 32'(out_valid), 32'd1);
        chk("clean0_data", 32'(data_out), 32'h0);
        chk("clean0_syn", 32'(syndrome), 32'd0);
        chk("clean0_corr", 32'(corrected), 32'd0);
        code_in = 7'h74;
        tick();
        chk("cleanF_data", 32'(data_out), 32'hF);
        chk("cleanF_syn", 32'(syndrome), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("clean_cnt2", 32'(clean_cnt), 32'd2);

        // Single error at position 3.
        in_valid = 1'b1; code_in = 7'h0F;
        tick();
        chk("err_data", 32'(data_out), 32'h0);
        chk("err_syn", 32'(syndrome), 32'd3);
        chk("err_corr", 32'(corrected), 32'd1);
        chk("err_corr_cnt", 32'(corr_cnt), 32'd1);
        in_valid = 1'b0;

        // Clear counters.
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        chk("clr_corr", 32'(corr_cnt), 32'd0);
        chk("clr_clean", 32'(clean_cnt), 32'd0);

        // Every data value with every single flip (and none), back-to-back.
        in_valid = 1'b1;
        for (int d = 0; d < 16; d++) begin
            for (int f = 0; f < 8; f++) begin
                mask = (f == 0) ? 7'd0 : (7'd1 << (f - 1));
                w = enc(4'(d)) ^ mask;
                code_in = w;
                chk("sweep_in_ready", 32'(in_ready), 32'd1);
                tick();
                chk("sweep_valid", 32'(out_valid), 32'd1);
                chk("sweep_data", 32'(data_out), 32'(d));
                chk("sweep_syn", 32'(syndrome), 32'(f));
                chk("sweep_corr", 32'(corrected), 32'(f != 0));
            end
        end
        chk("sweep_clean_cnt", 32'(clean_cnt), 32'd16);
        chk("sweep_corr_cnt", 32'(corr_cnt), 32'd112);

        // Backpressure: held word is d=F with position 7 flipped.
        out_ready = 1'b0;
        code_in = enc(4'h5);
        #1;
        chk("bp_in_ready0", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(data_out), 32'hF);
            chk("bp_syn", 32'(syndrome), 32'd7);
            chk("bp_clean_cnt", 32'(clean_cnt), 32'd16);
            chk("bp_corr_cnt", 32'(corr_cnt), 32'd112);
        end
        out_ready = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("rel_valid", 32'(out_valid), 32'd1);
        chk("rel_data", 32'(data_out), 32'h5);
        chk("rel_syn", 32'(syndrome), 32'd0);
        chk("rel_clean_cnt", 32'(clean_cnt), 32'd17);

        // Saturation and clear on the 2-bit-counter instance.
        s_in_valid = 1'b1; s_code_in = 7'h0F;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_sat = (k > 3) ? 3 : k;
            chk("sat_corr_cnt", 32'(s_corr_cnt), 32'(exp_sat));
        end
        s_clear_cnt = 1'b1;
        tick();
        chk("sat_clear_wins", 32'(s_corr_cnt), 32'd0);
        s_clear_cnt = 1'b0;
        tick();
        s_in_valid = 1'b0;
        chk("sat_after_clear", 32'(s_corr_cnt), 32'd1);
        chk("sat_clean_cnt", 32'(s_clean_cnt), 32'd0);
        chk("sat_data", 32'(s_data_out), 32'h0);
        chk("sat_syn", 32'(s_syndrome), 32'd3);
        chk("sat_corrected", 32'(s_corrected), 32'd1);
        chk("sat_valid", 32'(s_out_valid), 32'd1);
        chk("sat_in_ready", 32'(s_in_ready), 32'd1);

        // Asynchronous reset while a word is held and another is being offered.
        in_valid = 1'b1; code_in = enc(4'h9);
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(data_out), 32'd0);
        chk("arst_syn", 32'(syndrome), 32'd0);
        chk("arst_corrected", 32'(corrected), 32'd0);
        chk("arst_corr_cnt", 32'(corr_cnt), 32'd0);
        chk("arst_clean_cnt", 32'(clean_cnt), 32'd0);
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        in_valid = 1'b1; code_in = 7'h00;
        tick();
        in_valid = 1'b0;
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_syn", 32'(syndrome), 32'd7);
        chk("zero_data", 32'(data_out), 32'h8);
        chk("zero_corr", 32'(corrected), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hamming_decoder_odd.md
# hamming_decoder_odd

Single-error-correcting Hamming(7,4) decoder for the team's odd-parity codeword format, the receive-side counterpart of the 4-bit odd-parity encoder. It accepts one 7-bit codeword per valid/ready transfer, computes the 3-bit syndrome, corrects any single-bit error, and presents the 4 data bits one cycle later through a registered output stage with backpressure. Saturating counters of corrected and clean words support link-quality monitoring.

## Interface
- CNT_W, 16, width of each statistics counter (≥ 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  code_in is valid this cycle
- in_ready  out  1  decoder accepts code_in this cycle
- code_in  in  7  codeword; bit i = Hamming position i+1: [0]=p1, [1]=p2, [2]=d, [3]=p3, [4]=c, [5]=b, [6]=a
- out_valid  out  1  data_out/syndrome/corrected are valid
- out_ready  in  1  downstream accepts output
- data_out  out  4  corrected data {a,b,c,d}
- syndrome  out  3  {s4,s2,s1} of the accepted word; 0 = clean
- corrected  out  1  a bit was flipped (syndrome != 0)
- clear_cnt  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  words with nonzero syndrome, saturating
- clean_cnt  out  CNT_W  words with zero syndrome, saturating

## Operation
- Odd parity: each check group XORs to 1 in a valid word.
- s1 = ~(code[0]^code[2]^code[4]^code[6]); s2 = ~(code[1]^code[2]^code[5]^code[6]); s4 = ~(code[3]^code[4]^code[5]^code[6]).
- Nonzero syndrome S: invert code bit S-1, then extract data. Zero: pass through.
- data_out = {fixed[6], fixed[5], fixed[4], fixed[2]}.
- Double errors are miscorrected by construction; no detection is required or provided.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- in_ready = !out_valid | out_ready (combinational; single output register, no skid buffer).
- On transfer in: register data_out, syndrome, corrected; set out_valid. Output completes without a new input: clear out_valid.
- Counters increment on transfer in (corr_cnt if syndrome != 0, else clean_cnt), saturate at 2^CNT_W-1 and hold.
- clear_cnt and an increment in the same cycle: clear wins, counter = 0.

## Timing
- Latency: codeword accepted at edge N, outputs valid after edge N.
- Throughput: one word per cycle while out_ready = 1.
- out_valid = 1 and out_ready = 0: outputs held stable, in_ready = 0, code_in ignored.
- Reset (async assert, sync release): out_valid 0, data_out 0, syndrome 0, corrected 0, corr_cnt 0, clean_cnt 0. A word in flight is discarded; nothing is emitted after reset.
- in_ready depends on out_ready only; the design has no combinational path from in_valid to any output.

## Structure
- Package hamming_odd_pkg: localparams for bit positions (P1_IDX=0, P2_IDX=1, D_IDX=2, P3_IDX=3, C_IDX=4, B_IDX=5, A_IDX=6), CODE_W=7, DATA_W=4, SYN_W=3. The future odd-parity encoder rewrite shares this package.
- Sub-module hamming_syndrome_odd: combinational code[6:0] → syndrome[2:0], fixed[6:0], data[3:0]. The top module holds the handshake register and counters.

## Test plan
- Clean words: 7'h0B → data_out 4'h0, syndrome 0, corrected 0; 7'h74 → 4'hF, syndrome 0; clean_cnt = 2.
- Single error: 7'h0F (bit 2 of 7'h0B flipped) → data_out 4'h0, syndrome 3'd3, corrected 1, corr_cnt = 1.
- All 16 data values × all 7 single-bit flips plus no flip, streamed back-to-back with out_ready = 1. Required response: every data_out matches the original value, syndrome equals the flipped position, one word per cycle, clean_cnt = 16, corr_cnt = 112.
- Backpressure: out_ready = 0 for 5 cycles with in_valid = 1. Required response: in_ready = 0, outputs stable, counters unchanged. Release: the next word is accepted on the same edge the held word leaves.
- Saturation/clear with CNT_W = 2: 5 corrupted words → corr_cnt holds at 3. clear_cnt asserted together with a corrupted word → corr_cnt = 0.
- Async reset mid-stream while out_valid = 1: all outputs 0 immediately, no stale word after rst_n rises. Input 7'h00 afterwards → syndrome 3'd7, data_out 4'h8.
